// File: rtl/fifo_word_serializer_pkg.sv
// Shared defaults, beat-count helper and FSM encoding for the FIFO word serializer.
package fifo_word_serializer_pkg;

  localparam int unsigned IN_W_DEF  = 140;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops whole words from a show-ahead FIFO and streams them LSB-first as OUT_W-bit beats,
// flagging the final beat of each word; back-to-back words run at one beat per cycle.
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             rdclk,
  input  logic             rdrst,
  input  logic             fifo_rdempty,
  input  logic [IN_W-1:0]  fifo_rddata,
  output logic             fifo_rden,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned BEATS = ceil_div(IN_W, OUT_W);
  localparam int unsigned SH_W  = BEATS * OUT_W;
  localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(BEATS - 1);

  state_e            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [SH_W-1:0]   sh_next_c;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              vld_q, vld_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_c;
  logic              pop_c;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: advance on accepted beats, pop a new word when idle or on last-beat accept.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bcnt_d    = bcnt_q;
    vld_d     = vld_q;
    data_d    = data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    sh_next_c = sh_q >> OUT_W;
    accept_c  = vld_q && out_ready;
    pop_c     = !rdrst && !fifo_rdempty &&
                ((state_q == ST_IDLE) || (accept_c && last_q));

    if (accept_c && !last_q) begin
      sh_d   = sh_next_c;
      data_d = sh_next_c[OUT_W-1:0];
      bcnt_d = bcnt_q + BC_W'(1);
      last_d = ((bcnt_q + BC_W'(1)) == LAST_IDX);
    end else if (accept_c && last_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!pop_c) begin
        vld_d   = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end

    // A pop overrides the drain path: the new word's beat 0 follows with no bubble.
    if (pop_c) begin
      sh_d    = SH_W'(fifo_rddata);
      data_d  = fifo_rddata[OUT_W-1:0];
      vld_d   = 1'b1;
      bcnt_d  = '0;
      last_d  = (BEATS == 1);
      state_d = ST_SEND;
    end
  end

  assign fifo_rden = pop_c;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q == ST_SEND);
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: a queue-based FIFO model feeds the serializer, expected beats are
// queued per enqueued word, and an independent monitor checks every handshake.
module tb_fifo_word_serializer;

  localparam int unsigned IN_W  = 140;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NB    = (IN_W + OUT_W - 1) / OUT_W;

  logic             rdclk = 1'b0;
  logic             rdrst = 1'b1;
  logic             fifo_rdempty = 1'b1;
  logic [IN_W-1:0]  fifo_rddata = '0;
  logic             fifo_rden;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  fifo_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .rdclk       (rdclk),
    .rdrst       (rdrst),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rddata (fifo_rddata),
    .fifo_rden   (fifo_rden),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  always #5 rdclk = ~rdclk;

  typedef struct {
    int               id;
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t           exp_q[$];
  logic [IN_W-1:0] fq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int enq_cnt = 0;
  int pops_done = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_rden = 0;
  int first_v = -1;
  int last_v = -1;
  bit pop_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[IN_W-1:0];
  endfunction

  // Word enters the FIFO model; its padded LSB-first beats go to the scoreboard.
  task automatic enq(input logic [IN_W-1:0] w);
    logic [NB*OUT_W-1:0] p;
    beat_t b;
    p = (NB*OUT_W)'(w);
    fq.push_back(w);
    for (int k = 0; k < int'(NB); k++) begin
      b.id   = enq_cnt;
      b.data = p[k*OUT_W +: OUT_W];
      b.last = (k == int'(NB) - 1);
      exp_q.push_back(b);
    end
    enq_cnt++;
  endtask

  task automatic step(input logic rdy, input logic rst);
    @(negedge rdclk);
    if (pop_pend) begin
      fq.delete(0);
      pop_pend = 1'b0;
    end
    rdrst     = rst;
    out_ready = rdy;
    fifo_rdempty = (fq.size() == 0);
    if (fifo_rdempty) fifo_rddata = rand_word();
    else              fifo_rddata = fq[0];
    #1;
    cyc++;
    if (fifo_rden) begin
      pop_pend = 1'b1;
      pops_done++;
      n_rden++;
    end
    if (out_valid) begin
      n_valid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_rden  = 0;
    first_v = -1;
    last_v  = -1;
  endtask

  task automatic drain(input bit rnd);
    int guard;
    guard = 0;
    do begin
      step(rnd ? 1'($urandom_range(3) != 0) : 1'b1, 1'b0);
      guard++;
    end while ((fq.size() != 0 || out_valid || pop_pend) && guard < 3000);
    chk("drain_timeout", 32'(guard < 3000), 32'd1);
  endtask

  // Monitor: protocol rules, counter tracking and scoreboard comparison.
  logic [CNT_W-1:0] exp_cnt = '0;
  bit               rst_seen = 1'b0;
  bit               prev_stall = 1'b0;
  bit               prev_pop = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic             prev_last;

  always @(negedge rdclk) begin
    beat_t e;
    #2;
    if (rst_seen) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
    end
    chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    chk("busy", 32'(busy), 32'(out_valid));
    if (rdrst) begin
      chk("rden_in_reset", 32'(fifo_rden), 32'd0);
      exp_cnt = '0;
      while (exp_q.size() != 0 && exp_q[0].id < pops_done) exp_q.delete(0);
      rst_seen   = 1'b1;
      prev_stall = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      rst_seen = 1'b0;
      if (fifo_rdempty) chk("rden_while_empty", 32'(fifo_rden), 32'd0);
      if (!out_valid && !fifo_rdempty) chk("rden_idle_pop", 32'(fifo_rden), 32'd1);
      if (out_valid && !(out_ready && out_last)) chk("rden_in_send", 32'(fifo_rden), 32'd0);
      if (prev_pop) chk("pop_latency", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
          if (out_last) exp_cnt = exp_cnt + CNT_W'(1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_pop   = fifo_rden;
    end
  end

  initial begin
    logic [IN_W-1:0] w0;
    logic [IN_W-1:0] w2;
    bit r;
    int guard;
    w0 = 140'h123_4567_89AB_CDEF_0011_2233_4455_6677_8899;

    // Reset held with a word already waiting.
    enq(w0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Single word at full rate.
    clr_counts();
    step(1'b1, 1'b0);
    chk("pop_at_cycle0", 32'(fifo_rden), 32'd1);
    drain(1'b0);
    chk("single_beats", 32'(n_valid), 32'd9);
    chk("single_word_cnt", 32'(word_cnt), 32'd1);

    // Back-to-back words, no bubbles.
    clr_counts();
    for (int i = 0; i < 3; i++) enq(rand_word());
    drain(1'b0);
    chk("b2b_beats", 32'(n_valid), 32'd27);
    chk("b2b_span", 32'(last_v - first_v), 32'd26);
    chk("b2b_pops", 32'(n_rden), 32'd3);
    chk("b2b_word_cnt", 32'(word_cnt), 32'd4);

    // Backpressure on beat 4, then alternating ready.
    clr_counts();
    enq(w0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    r = 1'b1;
    guard = 0;
    while ((out_valid || pop_pend) && guard < 100) begin
      step(r, 1'b0);
      r = !r;
      guard++;
    end
    chk("bp_timeout", 32'(guard < 100), 32'd1);
    chk("bp_pops", 32'(n_rden), 32'd1);

    // Empty gap between words.
    enq(rand_word());
    drain(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_rden", 32'(fifo_rden), 32'd0);
    end
    w2 = rand_word();
    enq(w2);
    step(1'b1, 1'b0);
    chk("gap_pop", 32'(fifo_rden), 32'd1);
    step(1'b1, 1'b0);
    chk("gap_beat0_valid", 32'(out_valid), 32'd1);
    chk("gap_beat0_data", 32'(out_data), 32'(w2[OUT_W-1:0]));
    drain(1'b0);

    // Reset during beat 5 of word A with word B queued.
    enq(rand_word());
    enq(rand_word());
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("midrst_word_cnt0", 32'(word_cnt), 32'd0);
    drain(1'b0);
    chk("midrst_word_cnt1", 32'(word_cnt), 32'd1);

    // Random traffic and random backpressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) enq(rand_word());
      step(1'($urandom_range(3) != 0), 1'b0);
    end
    drain(1'b1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    @(negedge rdclk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Read-side consumer of the 140-bit clock-domain-crossing FIFO. It pops whole words from the FIFO's show-ahead read port and emits each word as a train of narrow beats on a valid/ready stream. The last beat of each word is flagged. It runs entirely in the FIFO read clock domain.

Parameters:
IN_W, 140, FIFO word width; must match the FIFO's FIFO_WIDTH.
OUT_W, 16, output beat width; 1 <= OUT_W <= IN_W.
BEATS, ceil(IN_W/OUT_W) (=9), beats per word; derived, not overridden.
CNT_W, 16, width of the completed-word counter.

Ports:
rdclk  in  1  clock, the FIFO read clock.
rdrst  in  1  reset, synchronous, active-high.
fifo_rdempty  in  1  FIFO read-side empty flag.
fifo_rddata  in  IN_W  FIFO show-ahead data; valid whenever fifo_rdempty=0.
fifo_rden  out  1  FIFO pop strobe; data is taken in the same cycle.
out_valid  out  1  beat valid.
out_data  out  OUT_W  beat data.
out_last  out  1  marks the final beat of a word.
out_ready  in  1  downstream accept.
busy  out  1  high while a word is held (state SEND).
word_cnt  out  CNT_W  number of fully transmitted words; wraps modulo 2^CNT_W.

Behaviour:
- Single clock domain. The FIFO already synchronises the pointers, so this block has no internal synchronisers.
- Reset applies on a rdclk edge while rdrst=1. Register reset values: state=IDLE, shift register=0, beat counter=0, out_valid=0, out_data=0, out_last=0, word_cnt=0.
- fifo_rden is combinational and is forced to 0 while rdrst=1.
- States:
  - IDLE: no word held.
  - SEND: a word is held and beats are being presented.
- Pop condition: fifo_rden = !rdrst && !fifo_rdempty && (state==IDLE || (out_valid && out_ready && out_last)).
- On a pop:
  - Shift register <= fifo_rddata, zero-extended to BEATS*OUT_W bits.
  - out_data <= fifo_rddata[OUT_W-1:0]; out_valid <= 1; beat counter <= 0; state <= SEND.
  - out_last <= 1 only if BEATS==1.
- Latency: the word is visible in IDLE at cycle t, pop happens at t, the first beat is valid at t+1.
- Beat order is LSB first. Beat k carries word bits [k*OUT_W +: OUT_W].
  - The final beat is zero-padded above bit IN_W-1.
  - Default case: beat 8 = {4'b0, word[139:128]}.
- Stream rule: while out_valid=1 and out_ready=0, out_data and out_last stay stable. out_valid is never withdrawn before acceptance.
- Accepted non-last beat (out_valid && out_ready && !out_last):
  - Shift right by OUT_W; present the next slice; beat counter += 1.
  - out_last <= (beat counter+1 == BEATS-1).
- Accepted last beat:
  - word_cnt += 1.
  - If fifo_rdempty=0: pop in the same cycle and present the new word's beat 0 next cycle. No bubble; sustained throughput is 1 beat per cycle.
  - Else: out_valid <= 0, out_last <= 0, state <= IDLE.
- fifo_rden is never asserted while fifo_rdempty=1, and never asserted in SEND except on last-beat acceptance.
- busy = (state==SEND).
- Reset mid-word: the partial word is discarded and its remaining beats are never emitted. A FIFO entry already popped is lost; this is accepted behaviour. The FIFO itself is reset by its own domain resets.
- word_cnt wrap: 0xFFFF + 1 -> 0x0000, with no flag.

Decomposition:
- Shared package holds:
  - IN_W/OUT_W defaults.
  - A ceil_div function used to derive BEATS.
  - The state encoding (IDLE=1'b0, SEND=1'b1).
- No sub-module is needed. Shift register, beat counter and FSM are small enough to sit inline in one module of about 150 lines.

Test Plan:
1. Reset: hold rdrst=1 for 3 cycles with fifo_rdempty=0 -> fifo_rden=0 throughout; out_valid=0, out_data=0, word_cnt=0.
2. Single word, out_ready=1: word=140'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899 presented at cycle 0 -> fifo_rden=1 at cycle 0.
   - Nine beats on cycles 1-9, the first being 16'h8899; out_last=1 only on cycle 9.
   - Final beat equals {4'b0, word[139:128]}.
   - busy drops and word_cnt=1 at cycle 10.
3. Back-to-back: three words queued, out_ready=1 -> 27 consecutive valid beats with no gap.
   - fifo_rden pulses coincide with each last-beat acceptance (cycles 9 and 18) plus the initial pop at cycle 0.
   - word_cnt=3.
4. Backpressure: out_ready low for 5 cycles on beat 4, toggled 1010 on the remaining beats -> out_data/out_last stable while stalled; beat sequence identical to scenario 2; exactly one pop per word.
5. Empty boundary: FIFO goes empty after word 1, word 2 arrives 4 cycles after the last beat -> out_valid=0 and state IDLE in the gap; fifo_rden=0 while empty; word 2 beat 0 valid 1 cycle after its arrival.
6. Reset mid-word: assert rdrst during beat 5 of word A with word B queued -> outputs clear next edge; after release, B is popped and emitted from beat 0; no A beats reappear; word_cnt=0 until B completes, then 1.
